// File: rtl/dmem_byte_arbiter_if.sv
// Requester-side handshake bundle for one port of the byte-RAM arbiter.
// The requester drives the master side; the arbiter implements the slave side.
interface dmem_byte_arbiter_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [2:0]      funct3;
  logic            done;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, wdata, funct3, input done, rdata);
  modport slave  (input req, we, addr, wdata, funct3, output done, rdata);
endinterface

// File: rtl/dmem_byte_arbiter.sv
// Two-port arbiter onto a byte-wide synchronous-read RAM; word/half accesses are
// serialised into byte operations and load data is extended per RV32 funct3.
//
// state   | meaning
// IDLE    | sample requests, grant one port (round-robin on tie)
// XFER    | one RAM byte per cycle, k = 0..N-1
// LAST_RD | capture the final load byte returned by the RAM
// DONE    | done/err pulse on the granted port
module dmem_byte_arbiter #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  dmem_byte_arbiter_if.slave m0,
  dmem_byte_arbiter_if.slave m1,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, LAST_RD, DONE} state_t;

  state_t            state_q, state_d;
  logic              port_q, port_d, rr_q, rr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        k_q, k_d;
  logic [XLEN-1:0]   buf_q, buf_d;
  logic [XLEN-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              err_q, err_d, busy_q, busy_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;

  logic              gnt;
  logic              g_we;
  logic [XLEN-1:0]   g_addr, g_wdata;
  logic [2:0]        g_f3;
  logic [2:0]        n_cur;
  logic              finish;
  int                lane;

  // 0 means illegal; loads of 4/5 are unsigned variants, stores have no such forms
  function automatic logic [2:0] nbytes(input logic we, input logic [2:0] f3);
    case (f3)
      3'd0:    nbytes = 3'd1;
      3'd1:    nbytes = 3'd2;
      3'd2:    nbytes = 3'd4;
      3'd4:    nbytes = we ? 3'd0 : 3'd1;
      3'd5:    nbytes = we ? 3'd0 : 3'd2;
      default: nbytes = 3'd0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] b, input logic [2:0] f3);
    case (f3)
      3'd0:    extend = {{(XLEN-8){b[7]}}, b[7:0]};
      3'd4:    extend = {{(XLEN-8){1'b0}}, b[7:0]};
      3'd1:    extend = {{(XLEN-16){b[15]}}, b[15:0]};
      3'd5:    extend = {{(XLEN-16){1'b0}}, b[15:0]};
      default: extend = b;
    endcase
  endfunction

  assign gnt     = (m0.req && m1.req) ? ~rr_q : m1.req;
  assign g_we    = gnt ? m1.we     : m0.we;
  assign g_addr  = gnt ? m1.addr   : m0.addr;
  assign g_wdata = gnt ? m1.wdata  : m0.wdata;
  assign g_f3    = gnt ? m1.funct3 : m0.funct3;
  assign n_cur   = nbytes(we_q, f3_q);

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    rr_d        = rr_q;
    we_d        = we_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    k_d         = k_q;
    buf_d       = buf_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    err_d       = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    finish      = 1'b0;
    lane        = 0;

    case (state_q)
      IDLE: begin
        if (m0.req || m1.req) begin
          port_d  = gnt;
          rr_d    = gnt;
          we_d    = g_we;
          base_d  = g_addr[ADDR_W-1:0];
          wdata_d = g_wdata;
          f3_d    = g_f3;
          k_d     = 2'd0;
          buf_d   = '0;
          if (nbytes(g_we, g_f3) == 3'd0) begin
            state_d = DONE;
            err_d   = 1'b1;
            if (gnt) begin
              done1_d  = 1'b1;
              rdata1_d = '0;
            end else begin
              done0_d  = 1'b1;
              rdata0_d = '0;
            end
          end else begin
            state_d     = XFER;
            ram_addr_d  = g_addr[ADDR_W-1:0];
            ram_we_d    = g_we;
            ram_wdata_d = g_wdata[7:0];
          end
        end
      end
      XFER: begin
        // RAM output now holds the byte addressed in the previous cycle
        if (!we_q && k_q != 2'd0) begin
          lane = int'(k_q) - 1;
          buf_d[lane*8 +: 8] = ram_rdata;
        end
        if ({1'b0, k_q} == n_cur - 3'd1) begin
          if (we_q) begin
            state_d = DONE;
            finish  = 1'b1;
          end else begin
            state_d = LAST_RD;
          end
        end else begin
          k_d         = k_q + 2'd1;
          ram_addr_d  = base_q + ADDR_W'(k_d);
          ram_we_d    = we_q;
          ram_wdata_d = wdata_q[int'(k_d)*8 +: 8];
        end
      end
      LAST_RD: begin
        lane = int'(k_q);
        buf_d[lane*8 +: 8] = ram_rdata;
        state_d = DONE;
        finish  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      if (port_q) begin
        done1_d = 1'b1;
        if (!we_q) rdata1_d = extend(buf_d, f3_q);
      end else begin
        done0_d = 1'b1;
        if (!we_q) rdata0_d = extend(buf_d, f3_q);
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      port_q      <= 1'b0;
      rr_q        <= 1'b1;
      we_q        <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= 3'd0;
      k_q         <= 2'd0;
      buf_q       <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      rr_q        <= rr_d;
      we_q        <= we_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      k_q         <= k_d;
      buf_q       <= buf_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign m0.done   = done0_q;
  assign m0.rdata  = rdata0_q;
  assign m1.done   = done1_q;
  assign m1.rdata  = rdata1_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_dmem_byte_arbiter.sv
// Directed bench for dmem_byte_arbiter with a behavioural byte RAM.
module tb_dmem_byte_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_byte_arbiter_if #(.XLEN(32)) i0();
  dmem_byte_arbiter_if #(.XLEN(32)) i1();

  logic       err, busy, ram_we;
  logic [9:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
  logic [7:0] mem [1024];
  logic [17:0] wlog [$];
  int order [$];
  int total = 0;
  int bad = 0;

  dmem_byte_arbiter #(.XLEN(32), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .m0(i0), .m1(i1), .err(err), .busy(busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wlog.push_back({ram_addr, ram_wdata});
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int p, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3);
    if (p == 0) begin
      i0.we = we; i0.addr = addr; i0.wdata = wdata; i0.funct3 = f3; i0.req = 1'b1;
    end else begin
      i1.we = we; i1.addr = addr; i1.wdata = wdata; i1.funct3 = f3; i1.req = 1'b1;
    end
  endtask

  task automatic access(input int p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3, input int exp_lat,
                        input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int c;
    @(posedge clk); #1;
    drive(p, we, addr, wdata, f3);
    @(posedge clk);
    for (c = 1; c <= 12; c++) begin
      @(negedge clk);
      if ((p == 0) ? i0.done : i1.done) break;
    end
    chk({tag, "_lat"}, c, exp_lat);
    chk({tag, "_rdata"}, (p == 0) ? i0.rdata : i1.rdata, exp_rd);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    chk({tag, "_otherdone"}, {31'b0, (p == 0) ? i1.done : i0.done}, 32'd0);
    i0.req = 1'b0;
    i1.req = 1'b0;
  endtask

  initial begin
    int w0;
    logic seen;
    logic [17:0] e;
    i0.req = 0; i0.we = 0; i0.addr = 0; i0.wdata = 0; i0.funct3 = 0;
    i1.req = 0; i1.we = 0; i1.addr = 0; i1.wdata = 0; i1.funct3 = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_we", {31'b0, ram_we}, 0);
    chk("rst_done", {30'b0, i0.done, i1.done}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_rd0", i0.rdata, 0);
    chk("rst_rd1", i1.rdata, 0);
    chk("rst_addr", {22'b0, ram_addr}, 0);
    rst = 1'b1;

    access(0, 1, 32'h010, 32'hDEADBEEF, 3'd2, 5, 32'h0, 0, "st_word");
    chk("st_word_mem", {mem[10'h013], mem[10'h012], mem[10'h011], mem[10'h010]}, 32'hDEADBEEF);
    chk("st_word_log0", {14'b0, wlog[0]}, {14'b0, 10'h010, 8'hEF});
    chk("st_word_log3", {14'b0, wlog[3]}, {14'b0, 10'h013, 8'hDE});

    access(0, 1, 32'h020, 32'h0000FF80, 3'd1, 3, 32'h0, 0, "st_half");
    access(0, 0, 32'h020, 32'h0, 3'd0, 3, 32'hFFFFFF80, 0, "lb");
    access(0, 0, 32'h020, 32'h0, 3'd4, 3, 32'h00000080, 0, "lbu");
    access(0, 0, 32'h020, 32'h0, 3'd1, 4, 32'hFFFFFF80, 0, "lh");
    access(0, 0, 32'h020, 32'h0, 3'd5, 4, 32'h0000FF80, 0, "lhu");
    access(1, 0, 32'h010, 32'h0, 3'd2, 6, 32'hDEADBEEF, 0, "lw_p1");
    chk("p0_rdata_kept", i0.rdata, 32'h0000FF80);

    access(1, 1, 32'hFFFF_F3FE, 32'h44332211, 3'd2, 5, 32'hDEADBEEF, 0, "st_wrap");
    chk("wrap_mem", {mem[10'h001], mem[10'h000], mem[10'h3FF], mem[10'h3FE]}, 32'h44332211);
    access(1, 0, 32'h3FE, 32'h0, 3'd2, 6, 32'h44332211, 0, "ld_wrap");

    w0 = wlog.size();
    access(0, 0, 32'h020, 32'h0, 3'd3, 1, 32'h0, 1, "ill_ld");
    access(0, 1, 32'h020, 32'h12345678, 3'd5, 1, 32'h0, 1, "ill_st");
    chk("ill_nowrite", wlog.size() - w0, 0);
    chk("ill_mem", {16'b0, mem[10'h021], mem[10'h020]}, 32'h0000FF80);

    // both requesters held high from reset
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1, 32'h100, 32'hA3A2A1A0, 3'd2);
    drive(1, 1, 32'h200, 32'hB3B2B1B0, 3'd2);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    wlog.delete();
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      @(negedge clk);
      if (i0.done && i1.done) order.push_back(9);
      else if (i0.done) order.push_back(0);
      else if (i1.done) order.push_back(1);
    end
    i0.req = 1'b0;
    i1.req = 1'b0;
    chk("rr_count", order.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_order%0d", i), (i < order.size()) ? order[i] : -1, i % 2);
    chk("rr_wcount", wlog.size(), 16);
    for (int i = 0; i < 16; i++) begin
      e = ((i / 4) % 2 == 1) ? {10'h200 + 10'(i % 4), 8'hB0 + 8'(i % 4)}
                             : {10'h100 + 10'(i % 4), 8'hA0 + 8'(i % 4)};
      chk($sformatf("rr_wlog%0d", i), (i < wlog.size()) ? {14'b0, wlog[i]} : 32'hFFFFFFFF, {14'b0, e});
    end

    access(0, 1, 32'h300, 32'h0, 3'd2, 5, 32'h0, 0, "clr300");
    access(0, 0, 32'h020, 32'h0, 3'd0, 3, 32'hFFFFFF80, 0, "lb2");

    // reset lands at the end of cycle 2 of a word store
    @(posedge clk); #1;
    drive(0, 1, 32'h300, 32'hCCBBAA99, 3'd2);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    i0.req = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_we", {31'b0, ram_we}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_rd0", i0.rdata, 0);
    rst = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | i0.done | i1.done;
    end
    chk("mid_rst_nodone", {31'b0, seen}, 0);
    chk("mid_rst_mem", {mem[10'h303], mem[10'h302], mem[10'h301], mem[10'h300]}, 32'h0000AA99);
    access(1, 0, 32'h300, 32'h0, 3'd2, 6, 32'h0000AA99, 0, "post_rst_lw");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_byte_arbiter.md
Name: dmem_byte_arbiter

Overview:
- Shares one single-port, byte-wide, synchronous-read data RAM between two requesters: port 0 = core load/store unit, port 1 = program/debug loader.
- Splits each byte, half or word access into sequential single-byte RAM operations.
- Assembles load data with sign or zero extension per funct3.
- Sits between the LSU/loader and the byte RAM. MMIO address decode (UART) happens upstream, so only RAM-bound accesses reach this block.

Parameters:
XLEN, 32, data/address width of requester ports.
ADDR_W, 10, RAM byte-address width (1024 bytes); requester addresses are truncated to ADDR_W LSBs.

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  synchronous reset, active-low.
m0_req  input  1  port 0 request; held high until m0_done.
m0_we  input  1  port 0 store (1) / load (0).
m0_addr  input  XLEN  port 0 byte address.
m0_wdata  input  XLEN  port 0 store data.
m0_funct3  input  3  port 0 access size/sign (RV32 load/store funct3).
m0_done  output  1  port 0 completion, one-cycle pulse.
m0_rdata  output  XLEN  port 0 load result; valid with m0_done, held until next m0_done.
m1_req, m1_we, m1_addr, m1_wdata, m1_funct3, m1_done, m1_rdata: same as port 0, for port 1.
err  output  1  one-cycle pulse with done when funct3 is illegal.
busy  output  1  high whenever state is not IDLE.
ram_addr  output  ADDR_W  RAM byte address.
ram_we  output  1  RAM write strobe.
ram_wdata  output  8  RAM write byte.
ram_rdata  input  8  RAM read byte; valid the cycle after ram_addr is presented with ram_we=0.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including both rdata registers.
  - Round-robin pointer is set so port 0 wins the first tie.
  - Reset mid-access aborts it: bytes already written stay in the RAM, no done is issued, and ram_we is 0 from the reset edge onward.
- FSM states: IDLE, XFER, LAST_RD, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - If exactly one req is high, that port is granted.
  - If both are high, the port not granted last time wins; the pointer updates on every grant.
  - On grant, latch we, addr[ADDR_W-1:0], wdata and funct3, clear byte counter k, then go to XFER.
  - No preemption once a port is granted.
- Byte count N from funct3:
  - Loads: 0 and 4 → 1; 1 and 5 → 2; 2 → 4.
  - Stores: 0 → 1; 1 → 2; 2 → 4.
  - All other codes (3, 6, 7, and 4/5 with we=1) are illegal.
- Illegal funct3:
  - Skip XFER and go directly to DONE.
  - No RAM write.
  - rdata = 0, err pulses with done.
- XFER, one byte per cycle, k = 0..N-1:
  - ram_addr = base + k modulo 2^ADDR_W (wraps; misaligned addresses allowed).
  - Store: ram_we=1, ram_wdata = wdata[8k+7:8k].
  - Load: ram_we=0; the byte returned for k is captured into lane k on the following cycle.
  - After k = N-1: store goes to DONE; load goes to LAST_RD.
- LAST_RD: capture final byte, go to DONE. ram_we=0.
- DONE:
  - Pulse the granted port's done; the other port's done stays 0.
  - Update that port's rdata:
    - funct3=0: sign-extend bit 7.
    - funct3=4: zero-extend byte.
    - funct3=1: sign-extend bit 15.
    - funct3=5: zero-extend half.
    - funct3=2: full word.
    - Stores leave rdata unchanged.
  - Go to IDLE.
- Latency (grant edge = cycle 0): done is high in cycle N+1 for stores and N+2 for loads. Illegal funct3 gives done in cycle 1.
- Requester drives req low in the cycle it sees done. If req is still high in the following IDLE cycle, it is treated as a new request.
- ram_we is 0 in every state except store XFER.
- busy is 0 only in IDLE.
- A port's req/addr/data changes while that port is not granted are harmless; the latched copy is used for a granted access.

Test Plan:
- Store word: m0 we=1, addr=0x010, wdata=0xDEADBEEF, funct3=2 → ram writes 0xEF@0x010, 0xBE@0x011, 0xAD@0x012, 0xDE@0x013 in cycles 1–4; m0_done in cycle 5.
- Loads from bytes 0x80@0x020, 0xFF@0x021:
  - funct3=0 → m0_rdata 0xFFFFFF80.
  - funct3=4 → 0x00000080.
  - funct3=1 → 0xFFFFFF80.
  - funct3=5 → 0x0000FF80.
  - Each load's done arrives 3 or 4 cycles after grant.
- Contention: m0_req and m1_req both high continuously from reset → grants alternate 0,1,0,1; each port's done pulses only for its own access; no byte of a word transfer is interleaved.
- Wrap: m1 store word addr=0x3FE, wdata=0x44332211, ADDR_W=10 → bytes at 0x3FE, 0x3FF, 0x000, 0x001 = 0x11, 0x22, 0x33, 0x44.
- Illegal: m0 funct3=3 load → done and err in cycle 1, m0_rdata=0, no ram_we. Store with funct3=5 → same, RAM unchanged.
- Reset at cycle 2 of a word store → state IDLE, ram_we=0 next cycle, only bytes 0–1 written, no done; a new request after rst is released is granted normally.
